// File: rtl/uart_rx_ctrl_param.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_param
//
// Parametrised UART receiver. Takes the raw pad-side RX line and delivers one
// framed character at a time to the register/FIFO layer. Bit timing is driven
// by an external oversample tick enable, so everything runs on the system clock.
// The line passes through a 2-flop synchroniser. Each bit is resolved by a
// 3-sample majority vote around its centre. Parity, framing and break
// conditions are reported alongside each character.
//
// Parameters:
//   OVERSAMPLE   oversample ticks per bit (even, 8..64)
//   DATA_BITS    data bits per frame (5..9)
//   PARITY_MODE  0 = none, 1 = even, 2 = odd
//   STOP_BITS    stop bits checked (1..2)
//
// Ports:
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   i_Os_Tick     oversample enable, one clk wide
//   i_Rx_Data     asynchronous serial line, idles high
//   o_Rx_Byte     last received character (LSB first on the line)
//   o_Rx_Valid    one-clk pulse when o_Rx_Byte and the error flags update
//   o_Parity_Err  parity mismatch on last frame, held until next o_Rx_Valid
//   o_Frame_Err   a stop bit sampled low on last frame, held until next o_Rx_Valid
//   o_Break       break detected, held until the line returns high
//   o_Busy        receiver is not idle
// ---------------------------------------------------------------------------
module uart_rx_ctrl_param #(
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int STOP_BITS   = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_Os_Tick,
    input  logic                 i_Rx_Data,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Valid,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Break,
    output logic                 o_Busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_S0   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_S1   = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] CNT_S2   = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic          ODD_PAR  = (PARITY_MODE == 2);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] PARITY = 3'd3;
    localparam logic [2:0] STOP   = 3'd4;
    localparam logic [2:0] BREAK  = 3'd5;

    logic                 rx_meta;
    logic                 rx_s;
    logic [2:0]           state;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_next;
    logic [IW-1:0]        idx;
    logic                 stop_idx;
    logic                 samp0;
    logic                 samp1;
    logic                 samp2;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 par_err_pend;
    logic                 frm_err_pend;
    logic                 maj_stored;
    logic                 maj_now;
    logic                 final_stop;
    logic                 par_exp;
    logic                 is_break;

    // Two-flop synchroniser; resets to the idle (high) line level so a reset
    // never looks like a start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Data;
            rx_s    <= rx_meta;
        end
    end

    // Capture the three samples around the bit centre.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            samp0 <= 1'b1;
            samp1 <= 1'b1;
            samp2 <= 1'b1;
        end else if (i_Os_Tick && (state != IDLE)) begin
            if (cnt == CNT_S0) samp0 <= rx_s;
            if (cnt == CNT_S1) samp1 <= rx_s;
            if (cnt == CNT_S2) samp2 <= rx_s;
        end
    end

    // maj_stored is valid once all three samples are in (used at end of bit);
    // maj_now folds in the live third sample so the final stop bit can be
    // decided on the very tick its last sample is taken.
    assign maj_stored = (samp0 & samp1) | (samp0 & samp2) | (samp1 & samp2);
    assign maj_now    = (samp0 & samp1) | (samp0 & rx_s)  | (samp1 & rx_s);
    assign final_stop = (STOP_BITS == 1) ? 1'b1 : stop_idx;
    assign par_exp    = (^shift) ^ ODD_PAR;
    assign is_break   = (shift == '0) && ((PARITY_MODE == 0) || !par_bit) && !maj_now;
    assign cnt_next   = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    assign o_Busy     = (state != IDLE);

    // Frame FSM. Everything advances only on oversample ticks; the tick counter
    // wraps at each bit boundary so the decision points repeat per bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            idx          <= '0;
            stop_idx     <= 1'b0;
            shift        <= '0;
            par_bit      <= 1'b0;
            par_err_pend <= 1'b0;
            frm_err_pend <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Rx_Valid   <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Break      <= 1'b0;
        end else begin
            o_Rx_Valid <= 1'b0;
            if (i_Os_Tick) begin
                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (!rx_s) state <= START;
                    end
                    START: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            // A start bit that reads high at its centre was a glitch.
                            if (maj_stored) begin
                                state <= IDLE;
                            end else begin
                                state        <= DATA;
                                idx          <= '0;
                                stop_idx     <= 1'b0;
                                par_bit      <= 1'b0;
                                par_err_pend <= 1'b0;
                                frm_err_pend <= 1'b0;
                            end
                        end
                    end
                    DATA: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            // Shift in from the top so the first (LSB) bit ends at bit 0.
                            shift <= {maj_stored, shift[DATA_BITS-1:1]};
                            if (idx == IDX_LAST) begin
                                state <= (PARITY_MODE != 0) ? PARITY : STOP;
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end
                    end
                    PARITY: begin
                        cnt <= cnt_next;
                        if (cnt == CNT_LAST) begin
                            par_bit      <= maj_stored;
                            par_err_pend <= (maj_stored != par_exp);
                            state        <= STOP;
                        end
                    end
                    STOP: begin
                        cnt <= cnt_next;
                        if (final_stop && (cnt == CNT_S2)) begin
                            // Finish early at the decision point to absorb baud skew
                            // between back-to-back frames.
                            cnt          <= '0;
                            o_Rx_Valid   <= 1'b1;
                            o_Rx_Byte    <= shift;
                            o_Parity_Err <= par_err_pend;
                            o_Frame_Err  <= frm_err_pend | !maj_now;
                            if (is_break) begin
                                o_Break <= 1'b1;
                                state   <= BREAK;
                            end else begin
                                state <= IDLE;
                            end
                        end else if (!final_stop && (cnt == CNT_LAST)) begin
                            if (!maj_stored) frm_err_pend <= 1'b1;
                            stop_idx <= 1'b1;
                        end
                    end
                    BREAK: begin
                        cnt <= '0;
                        if (rx_s) begin
                            o_Break <= 1'b0;
                            state   <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl_param
//
// Self-checking bench for uart_rx_ctrl_param. Two receivers share one clock:
// dut_a uses the defaults (8N1, tick every clk) and dut_b is 7 data bits, odd
// parity, 2 stop bits with a tick every 4th clk. Frames are driven onto each
// line with real-time bit periods, every o_Rx_Valid pulse is logged, and the
// log is compared against a frame-level model of what the receiver should
// report.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl_param;

    localparam int CLK_P = 100;
    localparam int BT_A  = 16 * CLK_P;
    localparam int BT_B  = 16 * 4 * CLK_P;
    localparam int BT_F  = (BT_A * 98) / 100;

    typedef struct packed {
        logic       brk;
        logic       ferr;
        logic       perr;
        logic [8:0] data;
    } rec_t;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       tick_a  = 1'b1;
    logic       tick_b  = 1'b0;
    logic       rx_a    = 1'b1;
    logic       rx_b    = 1'b1;
    logic [7:0] byte_a;
    logic [6:0] byte_b;
    logic       valid_a, perr_a, ferr_a, brk_a, busy_a;
    logic       valid_b, perr_b, ferr_b, brk_b, busy_b;

    rec_t q_a[$];
    rec_t q_b[$];
    int   n_cmp;
    int   n_bad;
    int   tdiv;

    uart_rx_ctrl_param dut_a (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_Os_Tick    (tick_a),
        .i_Rx_Data    (rx_a),
        .o_Rx_Byte    (byte_a),
        .o_Rx_Valid   (valid_a),
        .o_Parity_Err (perr_a),
        .o_Frame_Err  (ferr_a),
        .o_Break      (brk_a),
        .o_Busy       (busy_a)
    );

    uart_rx_ctrl_param #(
        .OVERSAMPLE  (16),
        .DATA_BITS   (7),
        .PARITY_MODE (2),
        .STOP_BITS   (2)
    ) dut_b (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_Os_Tick    (tick_b),
        .i_Rx_Data    (rx_b),
        .o_Rx_Byte    (byte_b),
        .o_Rx_Valid   (valid_b),
        .o_Parity_Err (perr_b),
        .o_Frame_Err  (ferr_b),
        .o_Break      (brk_b),
        .o_Busy       (busy_b)
    );

    // Free-running system clock.
    always #(CLK_P / 2) clk = ~clk;

    // dut_b gets a one-clk tick on every 4th clock, changed away from posedge.
    initial begin
        tdiv = 0;
        forever begin
            @(negedge clk);
            tdiv   = (tdiv + 1) % 4;
            tick_b = (tdiv == 0);
        end
    end

    // Log every valid pulse with the flags that accompany it.
    always @(negedge clk) begin
        if (valid_a) q_a.push_back(rec_t'({brk_a, ferr_a, perr_a, 1'b0, byte_a}));
        if (valid_b) q_b.push_back(rec_t'({brk_b, ferr_b, perr_b, 2'b00, byte_b}));
    end

    // Hard time limit so the run always ends.
    initial begin
        #(60_000_000);
        $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "[TB] watchdog");
    end

    // What the receiver should report for one frame, from the line format rules.
    function automatic rec_t expect_frame(input logic [8:0] data, input int nbits,
                                          input int pmode, input logic par,
                                          input logic [1:0] stops, input int nstop);
        rec_t       r;
        logic       ones;
        logic       last;
        logic [8:0] sh;
        sh   = data;
        ones = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            ones = ones ^ sh[0];
            sh   = sh >> 1;
        end
        last   = (nstop == 2) ? stops[1] : stops[0];
        r.data = data;
        r.perr = (pmode == 1) ? (par != ones) : (pmode == 2) ? (par != ~ones) : 1'b0;
        r.ferr = !stops[0] || ((nstop == 2) && !stops[1]);
        r.brk  = (data == 9'd0) && ((pmode == 0) || !par) && !last;
        return r;
    endfunction

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx_a = v;
        else            rx_b = v;
    endtask

    // Drive one frame; glitch_bit >= 0 puts a one-clk inverted pulse at the
    // centre of that data bit.
    task automatic send_frame(input int which, input logic [8:0] data, input int nbits,
                              input int pmode, input logic par, input logic [1:0] stops,
                              input int nstop, input int bt, input int glitch_bit);
        logic [8:0] sh;
        sh = data;
        set_line(which, 1'b0);
        #(bt);
        for (int i = 0; i < nbits; i++) begin
            set_line(which, sh[0]);
            if (i == glitch_bit) begin
                #(bt / 2 - CLK_P / 2);
                set_line(which, ~sh[0]);
                #(CLK_P);
                set_line(which, sh[0]);
                #(bt - bt / 2 - CLK_P / 2);
            end else begin
                #(bt);
            end
            sh = sh >> 1;
        end
        if (pmode != 0) begin
            set_line(which, par);
            #(bt);
        end
        for (int s = 0; s < nstop; s++) begin
            set_line(which, stops[s]);
            #(bt);
        end
        set_line(which, 1'b1);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++; if (byte_a !== 8'h00) begin n_bad++; $display("[TB] FAIL rst_byte_a: got %h want 00", byte_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_valid_a: got %b want 0", valid_a); end
        n_cmp++; if ({perr_a, ferr_a, brk_a} !== 3'b000) begin n_bad++; $display("[TB] FAIL rst_flags_a: got %b want 000", {perr_a, ferr_a, brk_a}); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL rst_busy_a: got %b want 0", busy_a); end
        n_cmp++; if ({byte_b, valid_b, perr_b, ferr_b, brk_b, busy_b} !== 12'h000) begin n_bad++; $display("[TB] FAIL rst_b: got %h want 000", {byte_b, valid_b, perr_b, ferr_b, brk_b, busy_b}); end
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_basic;
        rec_t exp;
        @(negedge clk);
        q_a.delete();
        fork
            send_frame(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, BT_A, -1);
            begin
                #(BT_A * 3);
                n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL basic_busy_mid: got %b want 1", busy_a); end
            end
        join
        @(negedge clk);
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy_a); end
        #(BT_A);
        exp = expect_frame(9'h0A5, 8, 0, 1'b0, 2'b11, 1);
        n_cmp++;
        if (q_a.size() != 1) begin n_bad++; $display("[TB] FAIL basic_count: got %0d want 1", q_a.size()); end
        else begin
            n_cmp++; if (q_a[0] !== exp) begin n_bad++; $display("[TB] FAIL basic_rec: got %h want %h", q_a[0], exp); end
            n_cmp++; if (byte_a !== 8'hA5) begin n_bad++; $display("[TB] FAIL basic_byte: got %h want a5", byte_a); end
        end
    endtask

    task automatic test_glitch;
        rec_t exp;
        @(negedge clk);
        q_a.delete();
        rx_a = 1'b0;
        repeat (6) @(negedge clk);
        rx_a = 1'b1;
        #(BT_A * 2);
        n_cmp++; if (q_a.size() != 0) begin n_bad++; $display("[TB] FAIL glitch_start_count: got %0d want 0", q_a.size()); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL glitch_start_busy: got %b want 0", busy_a); end
        send_frame(0, 9'h000, 8, 0, 1'b0, 2'b11, 1, BT_A, 3);
        #(BT_A * 2);
        exp = expect_frame(9'h000, 8, 0, 1'b0, 2'b11, 1);
        n_cmp++;
        if (q_a.size() != 1) begin n_bad++; $display("[TB] FAIL glitch_data_count: got %0d want 1", q_a.size()); end
        else begin
            n_cmp++; if (q_a[0] !== exp) begin n_bad++; $display("[TB] FAIL glitch_data_rec: got %h want %h", q_a[0], exp); end
        end
    endtask

    task automatic test_parity;
        rec_t       exp;
        logic [6:0] d;
        logic       p_ok;
        logic       par;
        logic [1:0] st;
        d    = 7'h55;
        p_ok = ~(^d);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            q_b.delete();
            par = (k == 1) ? ~p_ok : p_ok;
            st  = (k == 2) ? 2'b01 : 2'b11;
            send_frame(1, {2'b00, d}, 7, 2, par, st, 2, BT_B, -1);
            #(BT_B * 2);
            exp = expect_frame({2'b00, d}, 7, 2, par, st, 2);
            n_cmp++;
            if (q_b.size() != 1) begin n_bad++; $display("[TB] FAIL parity_count_%0d: got %0d want 1", k, q_b.size()); end
            else begin
                n_cmp++; if (q_b[0] !== exp) begin n_bad++; $display("[TB] FAIL parity_rec_%0d: got %h want %h", k, q_b[0], exp); end
            end
            n_cmp++; if (perr_b !== exp.perr) begin n_bad++; $display("[TB] FAIL parity_flag_%0d: got %b want %b", k, perr_b, exp.perr); end
            n_cmp++; if (ferr_b !== exp.ferr) begin n_bad++; $display("[TB] FAIL parity_ferr_%0d: got %b want %b", k, ferr_b, exp.ferr); end
        end
    endtask

    task automatic test_break;
        rec_t exp;
        @(negedge clk);
        q_a.delete();
        rx_a = 1'b0;
        #(BT_A * 15);
        n_cmp++; if (brk_a !== 1'b1) begin n_bad++; $display("[TB] FAIL break_held: got %b want 1", brk_a); end
        n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL break_busy: got %b want 1", busy_a); end
        #(BT_A * 5);
        rx_a = 1'b1;
        #(BT_A);
        n_cmp++; if (brk_a !== 1'b0) begin n_bad++; $display("[TB] FAIL break_clear: got %b want 0", brk_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("[TB] FAIL break_idle: got %b want 0", busy_a); end
        exp = expect_frame(9'h000, 8, 0, 1'b0, 2'b00, 1);
        n_cmp++;
        if (q_a.size() != 1) begin n_bad++; $display("[TB] FAIL break_count: got %0d want 1", q_a.size()); end
        else begin
            n_cmp++; if (q_a[0] !== exp) begin n_bad++; $display("[TB] FAIL break_rec: got %h want %h", q_a[0], exp); end
        end
        q_a.delete();
        send_frame(0, 9'h03C, 8, 0, 1'b0, 2'b11, 1, BT_A, -1);
        #(BT_A * 2);
        exp = expect_frame(9'h03C, 8, 0, 1'b0, 2'b11, 1);
        n_cmp++;
        if (q_a.size() != 1) begin n_bad++; $display("[TB] FAIL break_next_count: got %0d want 1", q_a.size()); end
        else begin
            n_cmp++; if (q_a[0] !== exp) begin n_bad++; $display("[TB] FAIL break_next_rec: got %h want %h", q_a[0], exp); end
        end
    endtask

    task automatic test_back_to_back;
        logic [8:0] bytes[3];
        rec_t       exp;
        bytes[0] = 9'h001;
        bytes[1] = 9'h0FE;
        bytes[2] = 9'h080;
        @(negedge clk);
        q_a.delete();
        for (int k = 0; k < 3; k++) send_frame(0, bytes[k], 8, 0, 1'b0, 2'b11, 1, BT_F, -1);
        #(BT_A * 2);
        @(negedge clk);
        n_cmp++;
        if (q_a.size() != 3) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d want 3", q_a.size()); end
        else begin
            for (int k = 0; k < 3; k++) begin
                exp = expect_frame(bytes[k], 8, 0, 1'b0, 2'b11, 1);
                n_cmp++; if (q_a[k] !== exp) begin n_bad++; $display("[TB] FAIL b2b_rec_%0d: got %h want %h", k, q_a[k], exp); end
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        rec_t exp;
        @(negedge clk);
        q_a.delete();
        fork
            send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1, BT_A, -1);
            begin
                #(BT_A * 5);
                n_cmp++; if (busy_a !== 1'b1) begin n_bad++; $display("[TB] FAIL rstmid_busy_before: got %b want 1", busy_a); end
                #(BT_A / 2);
                reset_n = 1'b0;
                #(10);
                n_cmp++; if (byte_a !== 8'h00) begin n_bad++; $display("[TB] FAIL rstmid_byte: got %h want 00", byte_a); end
                n_cmp++; if ({valid_a, perr_a, ferr_a, brk_a, busy_a} !== 5'b00000) begin n_bad++; $display("[TB] FAIL rstmid_flags: got %b want 00000", {valid_a, perr_a, ferr_a, brk_a, busy_a}); end
                #(BT_A * 5);
                @(negedge clk);
                reset_n = 1'b1;
            end
        join
        #(BT_A * 2);
        n_cmp++; if (q_a.size() != 0) begin n_bad++; $display("[TB] FAIL rstmid_no_valid: got %0d want 0", q_a.size()); end
        q_a.delete();
        send_frame(0, 9'h07E, 8, 0, 1'b0, 2'b11, 1, BT_A, -1);
        #(BT_A * 2);
        exp = expect_frame(9'h07E, 8, 0, 1'b0, 2'b11, 1);
        n_cmp++;
        if (q_a.size() != 1) begin n_bad++; $display("[TB] FAIL rstmid_next_count: got %0d want 1", q_a.size()); end
        else begin
            n_cmp++; if (q_a[0] !== exp) begin n_bad++; $display("[TB] FAIL rstmid_next_rec: got %h want %h", q_a[0], exp); end
        end
    endtask

    task automatic test_random;
        rec_t       exp_a[$];
        rec_t       exp_b[$];
        logic [8:0] d;
        logic       par;
        logic [1:0] st;
        @(negedge clk);
        q_a.delete();
        q_b.delete();
        for (int k = 0; k < 6; k++) begin
            d = 9'($urandom_range(0, 255));
            send_frame(0, d, 8, 0, 1'b0, 2'b11, 1, BT_A, -1);
            exp_a.push_back(expect_frame(d, 8, 0, 1'b0, 2'b11, 1));
            #(BT_A * $urandom_range(1, 3));
        end
        for (int k = 0; k < 4; k++) begin
            d   = 9'($urandom_range(0, 127));
            par = ~(^d[6:0]) ^ 1'($urandom_range(0, 1));
            st  = {($urandom_range(0, 3) != 0), 1'b1};
            send_frame(1, d, 7, 2, par, st, 2, BT_B, -1);
            exp_b.push_back(expect_frame(d, 7, 2, par, st, 2));
            #(BT_B * 2);
        end
        n_cmp++;
        if (q_a.size() != exp_a.size()) begin n_bad++; $display("[TB] FAIL rand_a_count: got %0d want %0d", q_a.size(), exp_a.size()); end
        else begin
            foreach (exp_a[k]) begin
                n_cmp++; if (q_a[k] !== exp_a[k]) begin n_bad++; $display("[TB] FAIL rand_a_rec_%0d: got %h want %h", k, q_a[k], exp_a[k]); end
            end
        end
        n_cmp++;
        if (q_b.size() != exp_b.size()) begin n_bad++; $display("[TB] FAIL rand_b_count: got %0d want %0d", q_b.size(), exp_b.size()); end
        else begin
            foreach (exp_b[k]) begin
                n_cmp++; if (q_b[k] !== exp_b[k]) begin n_bad++; $display("[TB] FAIL rand_b_rec_%0d: got %h want %h", k, q_b[k], exp_b[k]); end
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        n_cmp = 0;
        n_bad = 0;
        $display("[TB] starting uart_rx_ctrl_param bench");
        test_reset;
        test_basic;
        test_glitch;
        test_parity;
        test_break;
        test_back_to_back;
        test_reset_mid_frame;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
